collatz_engine: RTL and testbench

COLLATZ_ENGINE -- requirements
Module: collatz_engine

---
 rtl/collatz_pkg.sv | 13 +
 rtl/collatz_next.sv | 17 +
 rtl/collatz_engine.sv | 90 +++++++++
 tb/tb_collatz_engine.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared types and default widths for the Collatz iteration engine.
package collatz_pkg;

  localparam int DEF_N_BITS   = 32;
  localparam int DEF_CNT_BITS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/collatz_next.sv
// Combinational next-value step: halve if even, 3x+1 if odd, with overflow flag.
module collatz_next #(
  parameter int N_BITS = 32
) (
  input  logic [N_BITS-1:0] cur,
  output logic [N_BITS-1:0] nxt,
  output logic              ovf
);

  // Two extra bits hold the full 3x+1 result so overflow is just the top bits.
  logic [N_BITS+1:0] triple;

  assign triple = {2'b00, cur} + {1'b0, cur, 1'b0} + {{(N_BITS+1){1'b0}}, 1'b1};
  assign nxt    = cur[0] ? triple[N_BITS-1:0] : {1'b0, cur[N_BITS-1:1]};
  assign ovf    = cur[0] & (|triple[N_BITS+1:N_BITS]);

endmodule

// File: rtl/collatz_engine.sv
// Collatz step-count engine: IDLE/RUN/FIN FSM around a single collatz_next.
// Define COLLATZ_MAXVAL_EN to add the maxval output (peak value of the run).
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int N_BITS   = DEF_N_BITS,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [N_BITS-1:0]   n,
  output logic                busy,
  output logic                done,
  output logic [N_BITS-1:0]   dout,
  output logic [CNT_BITS-1:0] count,
`ifdef COLLATZ_MAXVAL_EN
  output logic [N_BITS-1:0]   maxval,
`endif
  output logic                err
);

  state_t            state;
  logic [N_BITS-1:0] nxt;
  logic              ovf;

  collatz_next #(.N_BITS(N_BITS)) u_next (
    .cur (dout),
    .nxt (nxt),
    .ovf (ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      dout   <= '0;
      count  <= '0;
`ifdef COLLATZ_MAXVAL_EN
      maxval <= '0;
`endif
    end else if (go) begin
      // A new start wins over everything, including an in-flight run or FIN.
      state  <= RUN;
      busy   <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
      dout   <= n;
      count  <= '0;
`ifdef COLLATZ_MAXVAL_EN
      maxval <= n;
`endif
    end else begin
      case (state)
        RUN: begin
          if (dout == '0 || &count || ovf) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (dout == N_BITS'(1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dout  <= nxt;
            count <= count + CNT_BITS'(1);
`ifdef COLLATZ_MAXVAL_EN
            if (nxt > maxval) maxval <= nxt;
`endif
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_engine.sv
// Self-checking bench: 32/16-bit engine plus an 8/4-bit engine for overflow and count saturation.
module tb_collatz_engine;

  typedef struct {
    longint unsigned cnt;
    longint unsigned dv;
    longint unsigned mx;
    longint unsigned err;
    longint unsigned lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go_a = 1'b0, go_b = 1'b0;
  logic [31:0] n_a = '0;
  logic [7:0]  n_b = '0;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [31:0] dout_a;
  logic [15:0] count_a;
  logic [7:0]  dout_b;
  logic [3:0]  count_b;
`ifdef COLLATZ_MAXVAL_EN
  logic [31:0] maxval_a;
  logic [7:0]  maxval_b;
`endif

  int   tests = 0;
  int   fails = 0;
  int   ndone_a = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  collatz_engine #(.N_BITS(32), .CNT_BITS(16)) dut_a (
    .clk(clk), .reset(reset), .go(go_a), .n(n_a), .busy(busy_a), .done(done_a),
    .dout(dout_a), .count(count_a),
`ifdef COLLATZ_MAXVAL_EN
    .maxval(maxval_a),
`endif
    .err(err_a)
  );

  collatz_engine #(.N_BITS(8), .CNT_BITS(4)) dut_b (
    .clk(clk), .reset(reset), .go(go_b), .n(n_b), .busy(busy_b), .done(done_b),
    .dout(dout_b), .count(count_b),
`ifdef COLLATZ_MAXVAL_EN
    .maxval(maxval_b),
`endif
    .err(err_b)
  );

  always @(posedge clk) if (done_a) ndone_a++;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference Collatz model with saturating step counter and overflow detection.
  function automatic exp_t model(input longint unsigned n0, input int nb, input int cb);
    exp_t e;
    longint unsigned v = n0;
    longint unsigned cmax = (64'd1 << cb) - 1;
    e.cnt = 0; e.err = 0; e.mx = n0;
    forever begin
      if (v == 0) begin e.err = 1; break; end
      if (v == 1) break;
      if (e.cnt == cmax) begin e.err = 1; break; end
      if (v % 2 == 1) begin
        if (3 * v + 1 >= (64'd1 << nb)) begin e.err = 1; break; end
        v = 3 * v + 1;
      end else begin
        v = v / 2;
      end
      e.cnt++;
      if (v > e.mx) e.mx = v;
    end
    e.dv  = v;
    e.lat = e.cnt + 2;
    return e;
  endfunction

  // Drive a go pulse at the current negedge and push the expected outcome.
  task automatic start(input bit sel, input longint unsigned v);
    if (sel) begin go_b = 1'b1; n_b = v[7:0]; sb.push_back(model(v, 8, 4)); end
    else     begin go_a = 1'b1; n_a = v[31:0]; sb.push_back(model(v, 32, 16)); end
    @(negedge clk);
    go_a = 1'b0;
    go_b = 1'b0;
  endtask

  // Wait for done (bounded), then pop the scoreboard and compare; returns at the done negedge.
  task automatic finish_run(input bit sel, input string tag);
    exp_t e;
    int lat = 1;
    while (!(sel ? done_b : done_a) && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_timeout"}, lat < 400, 1);
    check({tag, "_sb"}, sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_lat"},   lat, e.lat);
    check({tag, "_count"}, sel ? count_b : count_a, e.cnt);
    check({tag, "_dout"},  sel ? dout_b : dout_a, e.dv);
    check({tag, "_err"},   sel ? err_b : err_a, e.err);
    check({tag, "_busy"},  sel ? busy_b : busy_a, 0);
`ifdef COLLATZ_MAXVAL_EN
    check({tag, "_maxval"}, sel ? maxval_b : maxval_a, e.mx);
`endif
  endtask

  initial begin
    int base;
    longint unsigned hold_d, hold_c;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy",  busy_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_dout",  dout_a, 0);
    check("rst_count", count_a, 0);
    check("rst_err",   err_a, 0);
    check("rst_done_b", done_b, 0);

    // Basic runs on the wide engine.
    start(0, 6);
    check("n6_busy", busy_a, 1);
    finish_run(0, "n6");
    @(negedge clk);
    start(0, 27); finish_run(0, "n27"); @(negedge clk);
    start(0, 1);  finish_run(0, "n1");  @(negedge clk);
    start(0, 0);  finish_run(0, "n0");  @(negedge clk);

    // Outputs hold in IDLE and n is ignored without go.
    hold_d = dout_a; hold_c = count_a;
    n_a = 32'd12345;
    repeat (3) @(negedge clk);
    check("idle_dout",  dout_a, hold_d);
    check("idle_count", count_a, hold_c);
    check("idle_busy",  busy_a, 0);
    check("idle_done",  done_a, 0);

    // Overflow and count saturation on the narrow engine.
    start(1, 255); finish_run(1, "ovf255"); @(negedge clk);
    start(1, 7);   finish_run(1, "sat7");   @(negedge clk);

    // Restart three cycles into a 27 run: only the 7 run completes.
    base = ndone_a;
    start(0, 27);
    repeat (2) @(negedge clk);
    void'(sb.pop_back());
    start(0, 7);
    finish_run(0, "abort7");
    repeat (130) @(negedge clk);
    check("abort_ndone", ndone_a - base, 1);

    // go while in FIN: done for n=1 still seen, then a clean n=6 run.
    start(0, 1);
    finish_run(0, "fin1");
    start(0, 6);
    finish_run(0, "fin6");
    @(negedge clk);

    // Reset mid-run (with a simultaneous go) discards the run.
    base = ndone_a;
    start(0, 27);
    repeat (4) @(negedge clk);
    void'(sb.pop_back());
    reset = 1'b1; go_a = 1'b1; n_a = 32'd5;
    @(negedge clk);
    reset = 1'b0; go_a = 1'b0;
    check("mrst_busy",  busy_a, 0);
    check("mrst_done",  done_a, 0);
    check("mrst_dout",  dout_a, 0);
    check("mrst_count", count_a, 0);
    check("mrst_err",   err_a, 0);
    repeat (130) @(negedge clk);
    check("mrst_ndone", ndone_a - base, 0);
    start(0, 3);
    finish_run(0, "n3");
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
